// File: rtl/updown_rate_counter_if.sv
// updown_rate_counter_if: button inputs and count/mode/step outputs of updown_rate_counter
interface updown_rate_counter_if #(parameter int WIDTH = 4);
    logic [3:0]       buttons;
    logic [WIDTH-1:0] count;
    logic [1:0]       mode;
    logic             step;
    modport master (output buttons, input count, mode, step);
    modport slave  (input buttons, output count, mode, step);
endinterface

// File: rtl/updown_rate_counter.sv
// updown_rate_counter: button-driven up/down counter with auto-step modes; COUNTER_SATURATE_EN selects saturation over wrap
module updown_rate_counter #(
    parameter int WIDTH             = 4,
    parameter int CYCLES_PER_SECOND = 125_000_000,
    parameter int STEPS_PER_SECOND  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    updown_rate_counter_if.slave  bus
);
    localparam int CPS = CYCLES_PER_SECOND / STEPS_PER_SECOND;
    localparam int PW  = CPS > 1 ? $clog2(CPS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CPS - 1);
    typedef enum logic [1:0] {MANUAL = 2'b00, AUTO_UP = 2'b01, AUTO_DOWN = 2'b10} mode_e;
    logic [WIDTH-1:0] count_q, count_d, up, dn;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             step_q, step_d, last;
    logic [3:0]       btn_q, btn_edge;
`ifdef COUNTER_SATURATE_EN
    assign up = &count_q ? count_q : count_q + WIDTH'(1);
    assign dn = ~|count_q ? count_q : count_q - WIDTH'(1);
`else
    assign up = count_q + WIDTH'(1);
    assign dn = count_q - WIDTH'(1);
`endif
    assign btn_edge = bus.buttons & ~btn_q;
    assign last     = pre_q == PRE_LAST;
    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        pre_d   = '0;
        step_d  = 1'b0;
        if (btn_edge[3])
            count_d = '0;
        else if (btn_edge[2])
            mode_d = mode_q == MANUAL ? AUTO_UP : mode_q == AUTO_UP ? AUTO_DOWN : MANUAL;
        else if (mode_q == MANUAL)
            count_d = btn_edge[0] & ~btn_edge[1] ? up : btn_edge[1] & ~btn_edge[0] ? dn : count_q;
        else begin
            pre_d   = last ? '0 : pre_q + PW'(1);
            count_d = last ? (mode_q == AUTO_UP ? up : dn) : count_q;
            // a saturated step leaves count unchanged and so raises no pulse
            step_d  = last && count_d != count_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            mode_q  <= MANUAL;
            pre_q   <= '0;
            step_q  <= 1'b0;
            btn_q   <= bus.buttons;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            btn_q   <= bus.buttons;
        end
    end
    assign bus.count = count_q;
    assign bus.mode  = mode_q;
    assign bus.step  = step_q;
endmodule
